// File: rtl/heap_sort_tb_pkg.sv
// -----------------------------------------------------------------------------
// heap_sort_tb_pkg
// Shared definitions for the heap-sort output verifier:
//   HS_N_ELEM            default number of sorted elements per run
//   HS_ELEM_W            default element width (signed)
//   HS_DEFAULT_EXPECTED  default expected-value vector (1,2,3,4,5)
//   verify_state_t       verifier FSM state encoding
//   expected_at()        expected value for a given element index
// -----------------------------------------------------------------------------
package heap_sort_tb_pkg;

   localparam int HS_N_ELEM = 5;
   localparam int HS_ELEM_W = 32;

   // Ascending reference sequence: element i is expected to be i+1.
   function automatic int expected_at(input int i);
      return i + 1;
   endfunction

   localparam logic signed [HS_ELEM_W-1:0] HS_DEFAULT_EXPECTED [HS_N_ELEM] =
      '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};

   typedef enum logic [1:0] {
      CHECK = 2'd0,
      DONE  = 2'd1,
      FAIL  = 2'd2
   } verify_state_t;

endpackage

// File: rtl/heap_sort_expected_rom.sv
// -----------------------------------------------------------------------------
// heap_sort_expected_rom
// Combinational lookup of the expected sorted value for an element index.
// Ports:
//   idx       element index (0..N_ELEM-1)
//   expected  signed expected value for that index (0 for unused codes)
// -----------------------------------------------------------------------------
module heap_sort_expected_rom
   import heap_sort_tb_pkg::*;
#(
   parameter int N_ELEM = HS_N_ELEM,
   parameter int ELEM_W = HS_ELEM_W,
   localparam int IDX_W = $clog2(N_ELEM + 1)
) (
   input  logic [IDX_W-1:0]         idx,
   output logic signed [ELEM_W-1:0] expected
);

   // Table spans every idx code so the lookup never indexes out of range.
   logic signed [ELEM_W-1:0] w_table [2**IDX_W];

   for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_table
      if (gi < N_ELEM) begin : g_used
         assign w_table[gi] = ELEM_W'(expected_at(gi));
      end else begin : g_unused
         assign w_table[gi] = '0;
      end
   end

   assign expected = w_table[idx];

endmodule

// File: rtl/heap_sort_output_verifier.sv
// -----------------------------------------------------------------------------
// heap_sort_output_verifier
// Checks a stream of N_ELEM sorted elements against the ascending reference
// 1..N_ELEM and reports pass/fail, first error index, mismatch count, idle
// timeout and overrun.
// Ports:
//   system1000      clock (rising edge)
//   system1000_rst  synchronous active-high reset
//   in_valid        element present this cycle (no backpressure)
//   in_data         signed element from the sorter
//   done            run finished (pass or fail)
//   pass            run passed; meaningful while done=1
//   err_idx         index of first mismatch, N_ELEM if none
//   mismatch_cnt    number of mismatches, saturating at N_ELEM
//   timeout         run ended on idle timeout
//   overrun         in_valid seen after all elements were checked
// Configuration macro:
//   HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN  - first mismatch ends the run in FAIL
// -----------------------------------------------------------------------------
module heap_sort_output_verifier
   import heap_sort_tb_pkg::*;
#(
   parameter int N_ELEM  = HS_N_ELEM,
   parameter int ELEM_W  = HS_ELEM_W,
   parameter int TIMEOUT = 64,
   localparam int IDX_W  = $clog2(N_ELEM + 1),
   localparam int IDLE_W = $clog2(TIMEOUT + 1)
) (
   input  logic                     system1000,
   input  logic                     system1000_rst,
   input  logic                     in_valid,
   input  logic signed [ELEM_W-1:0] in_data,
   output logic                     done,
   output logic                     pass,
   output logic [IDX_W-1:0]         err_idx,
   output logic [IDX_W-1:0]         mismatch_cnt,
   output logic                     timeout,
   output logic                     overrun
);

   verify_state_t            r_state;
   logic [IDX_W-1:0]         r_idx;
   logic [IDLE_W-1:0]        r_idle;
   logic                     r_done;
   logic                     r_pass;
   logic [IDX_W-1:0]         r_err_idx;
   logic [IDX_W-1:0]         r_mismatch_cnt;
   logic                     r_timeout;
   logic                     r_overrun;

   logic signed [ELEM_W-1:0] w_expected;
   logic                     w_mismatch;
   logic                     w_last;
   logic [IDX_W-1:0]         w_cnt_sat;

   heap_sort_expected_rom #(
      .N_ELEM (N_ELEM),
      .ELEM_W (ELEM_W)
   ) u_rom (
      .idx      (r_idx),
      .expected (w_expected)
   );

   assign w_mismatch = (in_data != w_expected);
   assign w_last     = (r_idx == IDX_W'(N_ELEM - 1));
   assign w_cnt_sat  = (r_mismatch_cnt == IDX_W'(N_ELEM)) ? r_mismatch_cnt
                                                          : r_mismatch_cnt + 1'b1;

   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         r_state        <= CHECK;
         r_idx          <= '0;
         r_idle         <= '0;
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_err_idx      <= IDX_W'(N_ELEM);
         r_mismatch_cnt <= '0;
         r_timeout      <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         case (r_state)
            CHECK: begin
               // An accepted element wins over a timeout in the same cycle.
               if (in_valid) begin
                  r_idle <= '0;
                  if (w_mismatch) begin
                     r_mismatch_cnt <= w_cnt_sat;
                     // err_idx still at N_ELEM means no earlier mismatch.
                     if (r_err_idx == IDX_W'(N_ELEM))
                        r_err_idx <= r_idx;
                  end
`ifdef HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN
                  if (w_mismatch) begin
                     r_state <= FAIL;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b0;
                  end else if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_pass  <= (r_mismatch_cnt == '0);
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
`else
                  if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_pass  <= (r_mismatch_cnt == '0) && !w_mismatch;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
`endif
               end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                  r_idle    <= r_idle + 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= FAIL;
                  r_done    <= 1'b1;
                  r_pass    <= 1'b0;
               end else begin
                  r_idle <= r_idle + 1'b1;
               end
            end
            DONE: begin
               // Extra element after the run: sticky overrun, idx does not wrap.
               if (in_valid) begin
                  r_overrun <= 1'b1;
                  r_pass    <= 1'b0;
               end
            end
            FAIL: begin
               // Terminal until reset; inputs ignored.
            end
            default: begin
               r_state <= CHECK;
            end
         endcase
      end
   end

   assign done         = r_done;
   assign pass         = r_pass;
   assign err_idx      = r_err_idx;
   assign mismatch_cnt = r_mismatch_cnt;
   assign timeout      = r_timeout;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_heap_sort_output_verifier.sv
// -----------------------------------------------------------------------------
// tb_heap_sort_output_verifier
// Directed testbench for heap_sort_output_verifier with default parameters
// (N_ELEM=5, ELEM_W=32, TIMEOUT=64). Expected values are hand-computed.
// Honours HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN for the mismatch scenarios.
// -----------------------------------------------------------------------------
module tb_heap_sort_output_verifier;

   logic               clk;
   logic               srst;
   logic               in_valid;
   logic signed [31:0] in_data;
   logic               done;
   logic               pass;
   logic [2:0]         err_idx;
   logic [2:0]         mismatch_cnt;
   logic               timeout;
   logic               overrun;

   int n_total;
   int n_bad;

   heap_sort_output_verifier #(
      .N_ELEM  (5),
      .ELEM_W  (32),
      .TIMEOUT (64)
   ) dut (
      .system1000     (clk),
      .system1000_rst (srst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .done           (done),
      .pass           (pass),
      .err_idx        (err_idx),
      .mismatch_cnt   (mismatch_cnt),
      .timeout        (timeout),
      .overrun        (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Present one element for exactly one rising edge; return 1 time unit
   // after that edge so registered results are visible.
   task automatic push(input logic signed [31:0] v);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      srst = 1'b1;
      @(posedge clk);
      #1;
      srst = 1'b0;
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      srst     = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      idle(2);

      // Reset state
      check("rst_done",     int'(done),         0);
      check("rst_pass",     int'(pass),         0);
      check("rst_err_idx",  int'(err_idx),      5);
      check("rst_mm_cnt",   int'(mismatch_cnt), 0);
      check("rst_timeout",  int'(timeout),      0);
      check("rst_overrun",  int'(overrun),      0);
      srst = 1'b0;

      // Back-to-back 1..5
      for (int i = 1; i <= 4; i++) push(i);
      check("b2b_done_before_last", int'(done), 0);
      push(5);
      check("b2b_done",    int'(done),         1);
      check("b2b_pass",    int'(pass),         1);
      check("b2b_err_idx", int'(err_idx),      5);
      check("b2b_mm_cnt",  int'(mismatch_cnt), 0);

      // Overrun: an extra 6 after the run
      push(6);
      check("ovr_overrun", int'(overrun), 1);
      check("ovr_pass",    int'(pass),    0);
      check("ovr_done",    int'(done),    1);
      idle(3);
      check("ovr_held",    int'(overrun), 1);

      // 10 idle cycles between elements
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         idle(10);
         push(i);
      end
      check("gap_done",    int'(done),    1);
      check("gap_pass",    int'(pass),    1);
      check("gap_timeout", int'(timeout), 0);

      // Element arriving on the would-be timeout cycle wins
      do_reset();
      idle(63);
      push(1);
      check("edge_timeout", int'(timeout), 0);
      check("edge_done",    int'(done),    0);
      for (int i = 2; i <= 5; i++) push(i);
      check("edge_pass",    int'(pass),    1);

      // Stream 1,2,9,4,7
      do_reset();
      push(1); push(2); push(9);
      check("mm_err_idx", int'(err_idx), 2);
`ifdef HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN
      check("mm_done_early", int'(done),         1);
      check("mm_cnt_early",  int'(mismatch_cnt), 1);
      push(4); push(7);
      check("mm_cnt_final",  int'(mismatch_cnt), 1);
`else
      check("mm_done_early", int'(done),         0);
      check("mm_cnt_early",  int'(mismatch_cnt), 1);
      push(4); push(7);
      check("mm_cnt_final",  int'(mismatch_cnt), 2);
`endif
      check("mm_done",      int'(done),    1);
      check("mm_pass",      int'(pass),    0);
      check("mm_err_final", int'(err_idx), 2);

      // Full-width signed compare: 0x80000002 differs from 2 only in the MSB
      do_reset();
      push(1);
      push(32'sh8000_0002);
      check("sgn_err_idx", int'(err_idx),      1);
      check("sgn_mm_cnt",  int'(mismatch_cnt), 1);

      // Mismatch on the last element only
      do_reset();
      for (int i = 1; i <= 4; i++) push(i);
      push(0);
      check("last_err_idx", int'(err_idx),      4);
      check("last_mm_cnt",  int'(mismatch_cnt), 1);
      check("last_done",    int'(done),         1);
      check("last_pass",    int'(pass),         0);

      // Idle timeout after 1,2
      do_reset();
      push(1); push(2);
      idle(63);
      check("to_not_yet", int'(timeout), 0);
      check("to_done_no", int'(done),    0);
      idle(1);
      check("to_timeout", int'(timeout), 1);
      check("to_done",    int'(done),    1);
      check("to_pass",    int'(pass),    0);
      push(3);
      check("to_ignored_err", int'(err_idx),      5);
      check("to_ignored_mm",  int'(mismatch_cnt), 0);
      check("to_ignored_ovr", int'(overrun),      0);
      check("to_still_done",  int'(done),         1);

      // Reset mid-run discards progress
      do_reset();
      push(1); push(9); push(3);
      do_reset();
      check("mid_err_idx", int'(err_idx),      5);
      check("mid_mm_cnt",  int'(mismatch_cnt), 0);
      check("mid_done",    int'(done),         0);
      for (int i = 1; i <= 5; i++) push(i);
      check("mid_pass",    int'(pass),    1);
      check("mid_err_end", int'(err_idx), 5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/heap_sort_output_verifier.md
HEAP_SORT_OUTPUT_VERIFIER -- requirements
Module: heap_sort_output_verifier

Interface
REQ-001 The block SHALL have parameter N_ELEM, default 5, giving the number of sorted elements expected per run.
REQ-002 The block SHALL have parameter ELEM_W, default 32, giving the width of one signed element.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of idle cycles allowed between accepted elements.
REQ-004 The block SHALL have port system1000, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port system1000_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the sorter output element is present this cycle.
REQ-007 The block SHALL have port in_data, input, ELEM_W bits, signed: the sorter output element.
REQ-008 The block SHALL have port done, output, 1 bit: the run has finished, by either pass or fail.
REQ-009 The block SHALL have port pass, output, 1 bit: all N_ELEM elements matched and no error occurred; valid only while done is high.
REQ-010 The block SHALL have port err_idx, output, clog2(N_ELEM+1) bits: the index of the first mismatching element; equals N_ELEM if there was none.
REQ-011 The block SHALL have port mismatch_cnt, output, clog2(N_ELEM+1) bits: the number of mismatching elements.
REQ-012 The block SHALL have port timeout, output, 1 bit: the run ended because of the idle timeout.
REQ-013 The block SHALL have port overrun, output, 1 bit: in_valid was seen after all N_ELEM elements had been checked.

Function
REQ-014 The FSM SHALL have states CHECK, DONE and FAIL; the state after reset SHALL be CHECK.
REQ-015 In CHECK, each cycle with in_valid=1 SHALL compare in_data against expected[idx], signed and full width, then increment idx (0..N_ELEM-1).
REQ-016 Expected values SHALL be ascending: expected[i] = i+1, i.e. 1,2,3,4,5 by default.
REQ-017 On the first mismatch, err_idx SHALL capture idx; any mismatch SHALL increment mismatch_cnt, saturating at N_ELEM.
REQ-018 When the element at idx=N_ELEM-1 is accepted, the next state SHALL be DONE; done SHALL rise 1 cycle after that accept.
REQ-019 In DONE, pass SHALL be 1 iff mismatch_cnt=0, timeout=0 and overrun=0; all outputs SHALL then be held.
REQ-020 In DONE, in_valid=1 SHALL set overrun (sticky), which clears pass on the next cycle; idx SHALL NOT wrap.
REQ-021 The idle counter SHALL clear on each accepted element and increment on each CHECK cycle with in_valid=0.
REQ-022 When the idle counter reaches TIMEOUT, the block SHALL set timeout and enter FAIL; an element accepted in the same cycle SHALL take priority and clear the counter.
REQ-023 FAIL SHALL be terminal: done=1, pass=0, with inputs ignored until reset.
REQ-024 No element SHALL be dropped: in_valid is sampled every cycle in CHECK, and there is no backpressure.

Reset
REQ-025 While system1000_rst=1, the block SHALL set state=CHECK, idx=0, idle counter=0, done=0, pass=0, err_idx=N_ELEM, mismatch_cnt=0, timeout=0 and overrun=0.
REQ-026 Reset asserted mid-run SHALL discard all progress, and the next run SHALL start at idx=0 on the first cycle after reset deasserts.

Configuration
REQ-027 The block SHALL support macro HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN.
REQ-028 With HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN defined, the first mismatch SHALL move the FSM to FAIL on the next cycle, with mismatch_cnt=1.
REQ-029 Without HEAP_SORT_VERIFY_STOP_ON_MISMATCH_EN, the block SHALL keep checking all N_ELEM elements, count every mismatch, and end in DONE with pass=0.

Structure
REQ-030 Package heap_sort_tb_pkg SHALL hold N_ELEM, ELEM_W, the default expected-value vector and the verifier state enum.
REQ-031 Sub-module heap_sort_expected_rom SHALL map idx to expected[idx] combinationally.
REQ-032 The FSM, counters and flags SHALL reside in heap_sort_output_verifier itself.

Verification
REQ-033 Scenario: valid stream 1,2,3,4,5 on consecutive cycles -> done=1 exactly 1 cycle after the 5th, pass=1, err_idx=5, mismatch_cnt=0.
REQ-034 Scenario: stream 1,2,3,4,5 with 10 idle cycles between elements, TIMEOUT=64 -> pass=1, timeout=0.
REQ-035 Scenario: stream 1,2,9,4,7 -> err_idx=2; with the macro, FAIL after the 3rd element and mismatch_cnt=1; without it, DONE with mismatch_cnt=2 and pass=0.
REQ-036 Scenario: 1,2 then in_valid held 0 for 64 cycles -> timeout=1, done=1, pass=0, and a later 3 is ignored.
REQ-037 Scenario: 1..5 then an extra 6 -> overrun=1 and pass falls to 0 one cycle later.
REQ-038 Scenario: reset pulsed after 1,2,3, then 1..5 -> pass=1 with err_idx=5.
